// File: rtl/ps2_rx_fifo.sv
// Multi-channel PS/2 receive buffer: one FWFT FIFO per decoder channel, a shared select/pop read port and an irq.
// Optional build macro PS2_ERR_DROP_EN: frame-error strobes are dropped and flagged on err_seen_o instead of stored.
module ps2_rx_fifo #(
    parameter  int NCH   = 2,
    parameter  int DEPTH = 16,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [NCH*8-1:0]  code_i,
    input  logic [NCH-1:0]    strobe_i,
    input  logic [NCH-1:0]    err_i,
    input  logic [CHW-1:0]    sel_i,
    input  logic              rd_i,
    output logic [7:0]        data_o,
    output logic              err_o,
    output logic [CW-1:0]     count_o,
    output logic [NCH-1:0]    empty_o,
    output logic [NCH-1:0]    full_o,
    output logic [NCH-1:0]    overflow_o,
    input  logic [NCH-1:0]    clr_ovf_i,
    output logic [NCH-1:0]    err_seen_o,
    output logic              irq_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] FULLCNT = CW'(DEPTH);

    logic [8:0]     r_mem    [NCH][DEPTH];
    logic [AW-1:0]  r_wrPtr  [NCH];
    logic [AW-1:0]  r_rdPtr  [NCH];
    logic [CW-1:0]  r_count  [NCH];
    logic [NCH-1:0] r_overflow;

    logic [NCH-1:0] w_sel;
    logic [NCH-1:0] w_empty;
    logic [NCH-1:0] w_full;
    logic [NCH-1:0] w_store;
    logic [NCH-1:0] w_pop;
    logic [NCH-1:0] w_push;
    logic [NCH-1:0] w_ovfSet;
    logic [8:0]     w_entry  [NCH];

`ifdef PS2_ERR_DROP_EN
    logic [NCH-1:0] r_errSeen;
    logic [NCH-1:0] w_errDrop;
`endif

    // A pop on a full channel frees the slot that a same-cycle strobe then fills.
    always_comb begin
        w_sel    = '0;
        w_empty  = '0;
        w_full   = '0;
        w_store  = '0;
        w_pop    = '0;
        w_push   = '0;
        w_ovfSet = '0;
`ifdef PS2_ERR_DROP_EN
        w_errDrop = '0;
`endif
        for (int n = 0; n < NCH; n++) begin
            w_entry[n] = '0;
            w_empty[n] = (r_count[n] == '0);
            w_full[n]  = (r_count[n] == FULLCNT);
            w_sel[n]   = (sel_i == CHW'(n));
            w_pop[n]   = rd_i && w_sel[n] && !w_empty[n];
`ifdef PS2_ERR_DROP_EN
            w_store[n]   = strobe_i[n] && !err_i[n];
            w_errDrop[n] = strobe_i[n] && err_i[n];
            w_entry[n]   = {1'b0, code_i[8*n +: 8]};
`else
            w_store[n]   = strobe_i[n];
            w_entry[n]   = {err_i[n], code_i[8*n +: 8]};
`endif
            w_push[n]   = w_store[n] && (!w_full[n] || w_pop[n]);
            w_ovfSet[n] = w_store[n] && w_full[n] && !w_pop[n];
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int n = 0; n < NCH; n++) begin
                r_wrPtr[n] <= '0;
                r_rdPtr[n] <= '0;
                r_count[n] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (w_push[n]) begin
                    r_wrPtr[n] <= r_wrPtr[n] + AW'(1);
                end
                if (w_pop[n]) begin
                    r_rdPtr[n] <= r_rdPtr[n] + AW'(1);
                end
                if (w_push[n] && !w_pop[n]) begin
                    r_count[n] <= r_count[n] + CW'(1);
                end else if (w_pop[n] && !w_push[n]) begin
                    r_count[n] <= r_count[n] - CW'(1);
                end
                // A new overflow takes priority over a same-cycle clear so no event is lost.
                if (w_ovfSet[n]) begin
                    r_overflow[n] <= 1'b1;
                end else if (clr_ovf_i[n]) begin
                    r_overflow[n] <= 1'b0;
                end
            end
        end
    end

    // Storage carries no reset; unread slots are never presented because empty gates the read mux.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NCH; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wrPtr[n]] <= w_entry[n];
            end
        end
    end

`ifdef PS2_ERR_DROP_EN
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_errSeen <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (w_errDrop[n]) begin
                    r_errSeen[n] <= 1'b1;
                end else if (clr_ovf_i[n]) begin
                    r_errSeen[n] <= 1'b0;
                end
            end
        end
    end

    assign err_seen_o = r_errSeen;
`else
    assign err_seen_o = '0;
`endif

    // Out-of-range selects match no channel and so read as zero.
    always_comb begin
        data_o  = '0;
        err_o   = 1'b0;
        count_o = '0;
        for (int n = 0; n < NCH; n++) begin
            if (w_sel[n]) begin
                count_o = r_count[n];
                if (!w_empty[n]) begin
                    {err_o, data_o} = r_mem[n][r_rdPtr[n]];
                end
            end
        end
    end

    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign overflow_o = r_overflow;
    assign irq_o      = |(~w_empty);

endmodule
